// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds renamed instructions until both source tags are
// ready, then issues the lowest-index ready entry to the ALU, one per cycle.
module alu_reservation_station #(
  parameter int DEPTH  = 8,
  parameter int PREG_W = 7,
  parameter int ROB_W  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mispredict,
  input  logic                       alu_rs_valid_in,
  output logic                       alu_rs_ready_out,
  input  logic [PREG_W-1:0]          disp_pr1,
  input  logic [PREG_W-1:0]          disp_pr2,
  input  logic [PREG_W-1:0]          disp_prd,
  input  logic                       disp_pr1_rdy,
  input  logic                       disp_pr2_rdy,
  input  logic [3:0]                 disp_alu_op,
  input  logic                       disp_use_imm,
  input  logic [31:0]                disp_imm,
  input  logic [ROB_W-1:0]           disp_rob_tag,
  input  logic [2:0]                 wk_valid,
  input  logic [PREG_W-1:0]          wk_tag0,
  input  logic [PREG_W-1:0]          wk_tag1,
  input  logic [PREG_W-1:0]          wk_tag2,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [PREG_W-1:0]          issue_pr1,
  output logic [PREG_W-1:0]          issue_pr2,
  output logic [PREG_W-1:0]          issue_prd,
  output logic [3:0]                 issue_alu_op,
  output logic                       issue_use_imm,
  output logic [31:0]                issue_imm,
  output logic [ROB_W-1:0]           issue_rob_tag,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  rdy1_q, rdy1_d;
  logic [DEPTH-1:0]  rdy2_q, rdy2_d;
  logic [CNT_W-1:0]  occ_q, occ_d;

  logic [PREG_W-1:0] pr1_q [DEPTH];
  logic [PREG_W-1:0] pr2_q [DEPTH];
  logic [PREG_W-1:0] prd_q [DEPTH];
  logic [3:0]        op_q  [DEPTH];
  logic              imm_en_q [DEPTH];
  logic [31:0]       imm_q [DEPTH];
  logic [ROB_W-1:0]  rob_q [DEPTH];

  logic              selFound;
  logic [IDX_W-1:0]  selIdx;
  logic [IDX_W-1:0]  freeIdx;
  logic              accept;
  logic              fire;

  function automatic logic tagHit(input logic [PREG_W-1:0] t, input logic [2:0] v,
                                  input logic [PREG_W-1:0] a, input logic [PREG_W-1:0] b,
                                  input logic [PREG_W-1:0] c);
    return (v[0] && (a == t)) || (v[1] && (b == t)) || (v[2] && (c == t));
  endfunction

  // Descending scans leave the lowest matching index as the final winner.
  always_comb begin
    selFound = 1'b0;
    selIdx   = '0;
    freeIdx  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid_q[i] && rdy1_q[i] && rdy2_q[i]) begin
        selFound = 1'b1;
        selIdx   = IDX_W'(i);
      end
      if (!valid_q[i]) begin
        freeIdx = IDX_W'(i);
      end
    end
  end

  assign alu_rs_ready_out = (occ_q < DEPTH_C) && !mispredict;
  assign issue_valid      = selFound && !mispredict;
  assign accept           = alu_rs_valid_in && alu_rs_ready_out;
  assign fire             = issue_valid && issue_ready;
  assign occupancy        = occ_q;

  assign issue_pr1     = pr1_q[selIdx];
  assign issue_pr2     = pr2_q[selIdx];
  assign issue_prd     = prd_q[selIdx];
  assign issue_alu_op  = op_q[selIdx];
  assign issue_use_imm = imm_en_q[selIdx];
  assign issue_imm     = imm_q[selIdx];
  assign issue_rob_tag = rob_q[selIdx];

  // The write slot is free this cycle, so it can never be the slot being issued.
  always_comb begin
    valid_d = valid_q;
    rdy1_d  = rdy1_q;
    rdy2_d  = rdy2_q;
    occ_d   = occ_q + CNT_W'(accept) - CNT_W'(fire);
    for (int i = 0; i < DEPTH; i++) begin
      rdy1_d[i] = rdy1_q[i] | tagHit(pr1_q[i], wk_valid, wk_tag0, wk_tag1, wk_tag2);
      rdy2_d[i] = rdy2_q[i] | tagHit(pr2_q[i], wk_valid, wk_tag0, wk_tag1, wk_tag2);
    end
    if (fire) begin
      valid_d[selIdx] = 1'b0;
    end
    if (accept) begin
      valid_d[freeIdx] = 1'b1;
      rdy1_d[freeIdx]  = disp_pr1_rdy || (disp_pr1 == '0) ||
                         tagHit(disp_pr1, wk_valid, wk_tag0, wk_tag1, wk_tag2);
      rdy2_d[freeIdx]  = disp_use_imm || disp_pr2_rdy || (disp_pr2 == '0) ||
                         tagHit(disp_pr2, wk_valid, wk_tag0, wk_tag1, wk_tag2);
    end
    if (mispredict) begin
      valid_d = '0;
      occ_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      rdy1_q  <= '0;
      rdy2_q  <= '0;
      occ_q   <= '0;
    end else begin
      valid_q <= valid_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      occ_q   <= occ_d;
    end
  end

  // Payload is written only on accept; entry 0 resets to zero so reset-time issue fields are defined.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        pr1_q[i]    <= '0;
        pr2_q[i]    <= '0;
        prd_q[i]    <= '0;
        op_q[i]     <= '0;
        imm_en_q[i] <= 1'b0;
        imm_q[i]    <= '0;
        rob_q[i]    <= '0;
      end
    end else if (accept) begin
      pr1_q[freeIdx]    <= disp_pr1;
      pr2_q[freeIdx]    <= disp_pr2;
      prd_q[freeIdx]    <= disp_prd;
      op_q[freeIdx]     <= disp_alu_op;
      imm_en_q[freeIdx] <= disp_use_imm;
      imm_q[freeIdx]    <= disp_imm;
      rob_q[freeIdx]    <= disp_rob_tag;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: a slot-array reference model predicts
// each cycle's outputs and pushes expected issues; a monitor compares what the DUT issues.
module tb_alu_reservation_station;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        mispredict;
  logic        alu_rs_valid_in;
  logic        alu_rs_ready_out;
  logic [6:0]  disp_pr1, disp_pr2, disp_prd;
  logic        disp_pr1_rdy, disp_pr2_rdy;
  logic [3:0]  disp_alu_op;
  logic        disp_use_imm;
  logic [31:0] disp_imm;
  logic [3:0]  disp_rob_tag;
  logic [2:0]  wk_valid;
  logic [6:0]  wk_tag0, wk_tag1, wk_tag2;
  logic        issue_valid;
  logic        issue_ready;
  logic [6:0]  issue_pr1, issue_pr2, issue_prd;
  logic [3:0]  issue_alu_op;
  logic        issue_use_imm;
  logic [31:0] issue_imm;
  logic [3:0]  issue_rob_tag;
  logic [3:0]  occupancy;

  always #5 clk = ~clk;

  alu_reservation_station #(.DEPTH(8), .PREG_W(7), .ROB_W(4)) dut (
    .clk(clk), .reset(reset), .mispredict(mispredict),
    .alu_rs_valid_in(alu_rs_valid_in), .alu_rs_ready_out(alu_rs_ready_out),
    .disp_pr1(disp_pr1), .disp_pr2(disp_pr2), .disp_prd(disp_prd),
    .disp_pr1_rdy(disp_pr1_rdy), .disp_pr2_rdy(disp_pr2_rdy),
    .disp_alu_op(disp_alu_op), .disp_use_imm(disp_use_imm), .disp_imm(disp_imm),
    .disp_rob_tag(disp_rob_tag), .wk_valid(wk_valid),
    .wk_tag0(wk_tag0), .wk_tag1(wk_tag1), .wk_tag2(wk_tag2),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_pr1(issue_pr1), .issue_pr2(issue_pr2), .issue_prd(issue_prd),
    .issue_alu_op(issue_alu_op), .issue_use_imm(issue_use_imm), .issue_imm(issue_imm),
    .issue_rob_tag(issue_rob_tag), .occupancy(occupancy)
  );

  typedef struct packed {
    logic [6:0]  pr1;
    logic [6:0]  pr2;
    logic [6:0]  prd;
    logic [3:0]  op;
    logic        ui;
    logic [31:0] imm;
    logic [3:0]  rob;
  } iss_t;

  typedef struct {
    bit   v;
    bit   r1;
    bit   r2;
    iss_t f;
  } ent_t;

  iss_t expQ[$];
  ent_t m[DEPTH];
  int   nCompared = 0;
  int   nMismatch = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit wkHit(input logic [6:0] t);
    return (wk_valid[0] && wk_tag0 == t) || (wk_valid[1] && wk_tag1 == t) ||
           (wk_valid[2] && wk_tag2 == t);
  endfunction

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      m[i].v  = 0;
      m[i].r1 = 0;
      m[i].r2 = 0;
      m[i].f  = '0;
    end
    expQ.delete();
  endtask

  // Predict this cycle's outputs from the model, then advance the model past the coming edge.
  task automatic checkOutput();
    int cnt;
    int cand;
    int freeSlot;
    bit expIV, expRdy, fire, acc;
    cnt = 0; cand = -1; freeSlot = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m[i].v) cnt++;
      if (cand < 0 && m[i].v && m[i].r1 && m[i].r2) cand = i;
      if (freeSlot < 0 && !m[i].v) freeSlot = i;
    end
    expIV  = (cand >= 0) && !mispredict;
    expRdy = (cnt < DEPTH) && !mispredict;
    check("occupancy", occupancy, cnt);
    check("issue_valid", issue_valid, expIV);
    check("ready_out", alu_rs_ready_out, expRdy);
    fire = expIV && issue_ready;
    acc  = alu_rs_valid_in && expRdy;
    if (fire) expQ.push_back(m[cand].f);
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) m[i].v = 0;
    end else begin
      if (fire) m[cand].v = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (m[i].v && wkHit(m[i].f.pr1)) m[i].r1 = 1;
        if (m[i].v && wkHit(m[i].f.pr2)) m[i].r2 = 1;
      end
      if (acc) begin
        m[freeSlot].v  = 1;
        m[freeSlot].r1 = disp_pr1_rdy || disp_pr1 == 0 || wkHit(disp_pr1);
        m[freeSlot].r2 = disp_use_imm || disp_pr2_rdy || disp_pr2 == 0 || wkHit(disp_pr2);
        m[freeSlot].f  = '{pr1: disp_pr1, pr2: disp_pr2, prd: disp_prd, op: disp_alu_op,
                           ui: disp_use_imm, imm: disp_imm, rob: disp_rob_tag};
      end
    end
  endtask

  task automatic applyStimulus();
    #2;
    checkOutput();
    @(negedge clk);
  endtask

  task automatic idle(input logic ir);
    alu_rs_valid_in = 0;
    wk_valid        = 3'b000;
    mispredict      = 0;
    issue_ready     = ir;
  endtask

  task automatic disp(input logic [6:0] p1, input logic [6:0] p2, input logic [6:0] pd,
                      input logic r1, input logic r2, input logic ui, input logic [3:0] rob);
    alu_rs_valid_in = 1;
    disp_pr1 = p1; disp_pr2 = p2; disp_prd = pd;
    disp_pr1_rdy = r1; disp_pr2_rdy = r2; disp_use_imm = ui;
    disp_rob_tag = rob;
    disp_alu_op = 4'($urandom);
    disp_imm = $urandom;
  endtask

  task automatic wake(input int port, input logic [6:0] tag);
    wk_valid[port] = 1'b1;
    case (port)
      0: wk_tag0 = tag;
      1: wk_tag1 = tag;
      default: wk_tag2 = tag;
    endcase
  endtask

  // Monitor: every DUT issue handshake must match the oldest predicted issue.
  initial begin
    forever begin
      iss_t act;
      @(negedge clk);
      #3;
      if (reset && issue_valid && issue_ready) begin
        act = '{pr1: issue_pr1, pr2: issue_pr2, prd: issue_prd, op: issue_alu_op,
                ui: issue_use_imm, imm: issue_imm, rob: issue_rob_tag};
        if (expQ.size() == 0) begin
          nCompared++;
          nMismatch++;
          $display("[TB] FAIL unexpected_issue: got 0x%0h, expected no issue at %0t", act, $time);
        end else begin
          check("issue_fields", act, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 0;
    idle(0);
    disp_pr1 = 0; disp_pr2 = 0; disp_prd = 0; disp_pr1_rdy = 0; disp_pr2_rdy = 0;
    disp_alu_op = 0; disp_use_imm = 0; disp_imm = 0; disp_rob_tag = 0;
    wk_tag0 = 0; wk_tag1 = 0; wk_tag2 = 0;
    alu_rs_valid_in = 0;
    modelReset();
    #12;
    check("rst_occupancy", occupancy, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_ready_out", alu_rs_ready_out, 1);
    check("rst_issue_prd", issue_prd, 0);
    #2 reset = 1;
    @(negedge clk);

    $display("[TB] dispatch with ready operands");
    idle(1); disp(5, 6, 20, 1, 1, 0, 3); applyStimulus();
    check("tp1_prd", issue_prd, 20);
    check("tp1_rob", issue_rob_tag, 3);
    idle(1); applyStimulus();
    idle(1); applyStimulus();

    $display("[TB] wakeup after dispatch and in the dispatch cycle");
    idle(1); disp(9, 7, 21, 0, 0, 1, 4); applyStimulus();
    idle(1); applyStimulus();
    idle(1); applyStimulus();
    idle(1); wake(1, 9); applyStimulus();
    idle(1); applyStimulus();
    idle(1); disp(9, 7, 22, 0, 0, 1, 5); wake(1, 9); applyStimulus();
    idle(1); applyStimulus();

    $display("[TB] fill to capacity");
    for (int i = 0; i < DEPTH; i++) begin
      idle(0); disp(7'(10 + i), 0, 7'(60 + i), 0, 0, 1, 4'(i)); applyStimulus();
    end
    check("full_occupancy", occupancy, 8);
    idle(0); disp(40, 41, 42, 1, 1, 0, 12); applyStimulus();
    idle(0); wake(0, 13); applyStimulus();
    idle(1); applyStimulus();
    idle(0); disp(50, 0, 55, 1, 1, 1, 9); wake(2, 15); applyStimulus();
    check("slot3_first", issue_rob_tag, 9);
    idle(1); applyStimulus();
    idle(1); applyStimulus();
    idle(0); mispredict = 1; applyStimulus();
    idle(0); applyStimulus();

    $display("[TB] select priority with stalled ALU");
    for (int i = 0; i < 5; i++) begin
      idle(0); disp(7'(30 + i), 0, 7'(70 + i), 0, 0, 1, 4'(i)); applyStimulus();
    end
    idle(0); wake(0, 31); wake(2, 34); applyStimulus();
    for (int i = 0; i < 3; i++) begin
      check("hold_rob", issue_rob_tag, 1);
      check("hold_pr1", issue_pr1, 31);
      idle(0); applyStimulus();
    end
    idle(1); applyStimulus();
    idle(1); applyStimulus();

    $display("[TB] flush over dispatch and issue");
    idle(0); disp(80, 81, 82, 1, 1, 0, 6); applyStimulus();
    idle(0); disp(83, 84, 85, 1, 1, 0, 7); applyStimulus();
    check("pre_flush_occ", occupancy, 5);
    idle(1); disp(86, 87, 88, 1, 1, 0, 8); mispredict = 1; applyStimulus();
    idle(1); applyStimulus();

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      idle($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 9) < 7)
        disp(7'($urandom_range(0, 15)), 7'($urandom_range(0, 15)), 7'($urandom_range(0, 127)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 4'($urandom));
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 2) == 0) wake(p, 7'($urandom_range(0, 15)));
      mispredict = ($urandom_range(0, 49) == 0);
      applyStimulus();
    end

    $display("[TB] asynchronous reset mid-cycle");
    for (int i = 0; i < 3; i++) begin
      idle(0); disp(7'(90 + i), 0, 7'(100 + i), 1, 1, 1, 4'(i)); applyStimulus();
    end
    idle(0);
    #4 reset = 0;
    #1;
    check("async_issue_valid", issue_valid, 0);
    check("async_occupancy", occupancy, 0);
    check("async_ready_out", alu_rs_ready_out, 1);
    modelReset();
    @(negedge clk);
    #1 reset = 1;
    @(negedge clk);
    idle(1); applyStimulus();
    idle(1); disp(3, 0, 4, 1, 0, 0, 2); applyStimulus();
    idle(1); applyStimulus();
    idle(1); applyStimulus();

    check("queue_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
